// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard controller: in-flight slot payload, forward-select encodings.
package hazard_controller_pkg;

  // Default architectural register index width (32 registers).
  localparam int unsigned REG_IDX_W_DEF = 5;

  // Storage width of a slot's destination field; REG_IDX_W must not exceed it.
  localparam int unsigned SLOT_IDX_W = 8;

  localparam int unsigned FWD_W = 2;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_EXMEM   = 2'b01;
  localparam fwd_sel_t FWD_MEMWB   = 2'b10;

  // One in-flight instruction as seen by hazard detection.
  typedef struct packed {
    logic                  valid;
    logic [SLOT_IDX_W-1:0] dest;
    logic                  wr_en;
    logic                  is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A slot produces the value a Decode operand needs; index 0 optionally never matches.
  function automatic logic slot_matches(input slot_t                 s,
                                        input logic [SLOT_IDX_W-1:0] src,
                                        input logic                  use_src,
                                        input logic                  zero_reg);
    return s.valid && s.wr_en && use_src && (s.dest == src) &&
           !(zero_reg && (src == '0));
  endfunction

endpackage

// File: rtl/hazard_controller_inflight_tracker.sv
// Three-slot EX/MEM/WB shadow of the pipeline with bubble insert and operand match flags.
module inflight_tracker
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEF,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_i,
  input  logic [REG_IDX_W-1:0] id_dest_i,
  input  logic                 id_wr_en_i,
  input  logic                 id_is_load_i,
  input  logic [REG_IDX_W-1:0] id_src1_i,
  input  logic [REG_IDX_W-1:0] id_src2_i,
  input  logic                 id_use1_i,
  input  logic                 id_use2_i,
  output logic                 ex_is_load_c_o,
  output logic                 ex_match1_c_o,
  output logic                 ex_match2_c_o,
  output logic                 mem_match1_c_o,
  output logic                 mem_match2_c_o
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;

  logic [SLOT_IDX_W-1:0] src1_ext;
  logic [SLOT_IDX_W-1:0] src2_ext;

  assign src1_ext = SLOT_IDX_W'(id_src1_i);
  assign src2_ext = SLOT_IDX_W'(id_src2_i);

  // Next EX slot: the Decode instruction when it issues, otherwise a bubble.
  always_comb begin
    ex_d = SLOT_BUBBLE;
    if (issue_i) begin
      ex_d.valid   = 1'b1;
      ex_d.dest    = SLOT_IDX_W'(id_dest_i);
      ex_d.wr_en   = id_wr_en_i;
      ex_d.is_load = id_is_load_i;
    end
  end

  // Slot shift register; everything advances every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= SLOT_BUBBLE;
      mem_q <= SLOT_BUBBLE;
      wb_q  <= SLOT_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Operand match flags against the producers in EX and MEM.
  always_comb begin
    ex_is_load_c_o = ex_q.valid & ex_q.is_load;
    ex_match1_c_o  = slot_matches(ex_q,  src1_ext, id_use1_i, ZERO_REG);
    ex_match2_c_o  = slot_matches(ex_q,  src2_ext, id_use2_i, ZERO_REG);
    mem_match1_c_o = slot_matches(mem_q, src1_ext, id_use1_i, ZERO_REG);
    mem_match2_c_o = slot_matches(mem_q, src2_ext, id_use2_i, ZERO_REG);
  end

  // WB is tracked but never forwarded: the register file writes through in that stage.
  logic wb_unused;
  assign wb_unused = ^wb_q;

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, EX operand forwarding and taken-branch flush control for the 16-bit core.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEF,
  parameter int unsigned CNT_W     = 16,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_use1,
  input  logic                 id_use2,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 id_wr_en,
  input  logic                 id_is_load,
  input  logic                 ex_branch_taken,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [FWD_W-1:0]     fwd1_sel,
  output logic [FWD_W-1:0]     fwd2_sel,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  logic ex_is_load, ex_m1, ex_m2, mem_m1, mem_m2;
  logic stall, issue;

  fwd_sel_t         fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  inflight_tracker #(
    .REG_IDX_W (REG_IDX_W),
    .ZERO_REG  (ZERO_REG)
  ) u_tracker (
    .clk            (clk),
    .reset          (reset),
    .issue_i        (issue),
    .id_dest_i      (id_dest),
    .id_wr_en_i     (id_wr_en),
    .id_is_load_i   (id_is_load),
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_use1_i      (id_use1),
    .id_use2_i      (id_use2),
    .ex_is_load_c_o (ex_is_load),
    .ex_match1_c_o  (ex_m1),
    .ex_match2_c_o  (ex_m2),
    .mem_match1_c_o (mem_m1),
    .mem_match2_c_o (mem_m2)
  );

  // A taken branch squashes Decode, so it can never be the consumer of a load-use stall.
  always_comb begin
    stall = id_valid & ~ex_branch_taken & ex_is_load & (ex_m1 | ex_m2);
    issue = id_valid & ~stall & ~ex_branch_taken;
  end

  // Pipeline-register controls are combinational so they act in the same cycle.
  always_comb begin
    pc_write_en    = ~stall;
    if_id_write_en = ~stall;
    if_id_flush    = ex_branch_taken;
    id_ex_bubble   = stall | ex_branch_taken;
  end

  // Forward selects for the instruction entering EX; the newest producer wins.
  always_comb begin
    fwd1_d = FWD_REGFILE;
    fwd2_d = FWD_REGFILE;
    if (issue) begin
      if (ex_m1 && !ex_is_load) fwd1_d = FWD_EXMEM;
      else if (mem_m1)          fwd1_d = FWD_MEMWB;
      if (ex_m2 && !ex_is_load) fwd2_d = FWD_EXMEM;
      else if (mem_m2)          fwd2_d = FWD_MEMWB;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_branch_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Registered forward selects and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd1_q      <= FWD_REGFILE;
      fwd2_q      <= FWD_REGFILE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd1_sel    = fwd1_q;
  assign fwd2_sel    = fwd2_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller; a second 3-bit-counter instance checks saturation.
module tb_hazard_controller;

  localparam int unsigned RW  = 5;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 3;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_use1, id_use2, id_wr_en, id_is_load, ex_branch_taken;
  logic [RW-1:0] id_src1, id_src2, id_dest;

  logic pc_we, ifid_we, flush, bub;
  logic [1:0] f1, f2;
  logic [CW-1:0] sc, fc;

  logic s_pc_we, s_ifid_we, s_flush, s_bub;
  logic [1:0] s_f1, s_f2;
  logic [CWS-1:0] s_sc, s_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_IDX_W(RW), .CNT_W(CW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .pc_write_en(pc_we), .if_id_write_en(ifid_we), .if_id_flush(flush), .id_ex_bubble(bub),
    .fwd1_sel(f1), .fwd2_sel(f2), .stall_count(sc), .flush_count(fc)
  );

  hazard_controller #(.REG_IDX_W(RW), .CNT_W(CWS), .ZERO_REG(1'b1)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we), .if_id_flush(s_flush), .id_ex_bubble(s_bub),
    .fwd1_sel(s_f1), .fwd2_sel(s_f2), .stall_count(s_sc), .flush_count(s_fc)
  );

  typedef struct {
    logic v; logic [RW-1:0] s1; logic [RW-1:0] s2; logic u1; logic u2;
    logic [RW-1:0] d; logic wr; logic ld; logic br;
    logic pcwe; logic fl; logic bub; logic [1:0] f1; logic [1:0] f2; int sc; int fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input int v, input int s1, input int s2, input int u1, input int u2,
                               input int d, input int wr, input int ld, input int br,
                               input int pcwe, input int fl, input int bb,
                               input int ef1, input int ef2, input int esc, input int efc);
    vec_t t;
    t.v = v[0]; t.s1 = RW'(s1); t.s2 = RW'(s2); t.u1 = u1[0]; t.u2 = u2[0];
    t.d = RW'(d); t.wr = wr[0]; t.ld = ld[0]; t.br = br[0];
    t.pcwe = pcwe[0]; t.fl = fl[0]; t.bub = bb[0];
    t.f1 = 2'(ef1); t.f2 = 2'(ef2); t.sc = esc; t.fc = efc;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int s1, input int s2, input logic u1, input logic u2,
                       input int d, input logic wr, input logic ld, input logic br);
    id_valid = v; id_src1 = RW'(s1); id_src2 = RW'(s2); id_use1 = u1; id_use2 = u2;
    id_dest = RW'(d); id_wr_en = wr; id_is_load = ld; ex_branch_taken = br;
  endtask

  function automatic int sat_small(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  initial begin
    //              v s1 s2 u1 u2 d wr ld br  pcwe fl bub f1 f2 sc fc
    tbl.push_back(mkv(1, 0, 0, 0, 0, 2, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 0  R2 write, no readers
    tbl.push_back(mkv(1, 1, 3, 1, 1, 2, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 1  SUB R2<-R1-R3
    tbl.push_back(mkv(1, 2, 5, 1, 1, 4, 1, 0, 0,  1, 0, 0,  1, 0, 0, 0)); // 2  ADD R4<-R2+R5 -> 01
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 3  NOP
    tbl.push_back(mkv(1, 1, 3, 1, 1, 2, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 4  SUB R2
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 5  NOP
    tbl.push_back(mkv(1, 5, 2, 1, 1, 4, 1, 0, 0,  1, 0, 0,  0, 2, 0, 0)); // 6  ADD R4<-R5+R2 -> 10
    tbl.push_back(mkv(1, 1, 3, 1, 1, 2, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 7  SUB R2 (a)
    tbl.push_back(mkv(1, 6, 7, 1, 1, 2, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 8  SUB R2 (b)
    tbl.push_back(mkv(1, 5, 2, 1, 1, 4, 1, 0, 0,  1, 0, 0,  0, 1, 0, 0)); // 9  youngest wins -> 01
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0)); // 10 NOP
    tbl.push_back(mkv(1, 2, 4, 1, 1, 9, 1, 0, 0,  1, 0, 0,  0, 2, 0, 0)); // 11 R2 in wb: 00; R4 mem: 10
    tbl.push_back(mkv(1, 1, 0, 1, 0, 2, 1, 1, 0,  1, 0, 0,  0, 0, 0, 0)); // 12 LOAD R2
    tbl.push_back(mkv(1, 2, 5, 1, 1, 4, 1, 0, 0,  0, 0, 1,  0, 0, 1, 0)); // 13 load-use stall
    tbl.push_back(mkv(1, 2, 5, 1, 1, 4, 1, 0, 0,  1, 0, 0,  2, 0, 1, 0)); // 14 reissue -> 10
    tbl.push_back(mkv(1, 1, 0, 1, 0, 3, 1, 1, 0,  1, 0, 0,  0, 0, 1, 0)); // 15 LOAD R3
    tbl.push_back(mkv(1, 3, 6, 0, 1, 7, 1, 0, 0,  1, 0, 0,  0, 0, 1, 0)); // 16 R3 not read: no stall
    tbl.push_back(mkv(1, 1, 0, 1, 0, 2, 1, 1, 0,  1, 0, 0,  0, 0, 1, 0)); // 17 LOAD R2
    tbl.push_back(mkv(1, 2, 5, 1, 1, 4, 1, 0, 1,  1, 1, 1,  0, 0, 1, 1)); // 18 stall + branch -> flush
    tbl.push_back(mkv(1, 2, 5, 1, 1, 4, 1, 0, 0,  1, 0, 0,  2, 0, 1, 1)); // 19 load now in mem -> 10
    tbl.push_back(mkv(1, 1, 3, 1, 1, 0, 1, 0, 0,  1, 0, 0,  0, 0, 1, 1)); // 20 producer to R0
    tbl.push_back(mkv(1, 0, 0, 1, 1, 5, 1, 0, 0,  1, 0, 0,  0, 0, 1, 1)); // 21 R0 reader -> 00
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 1, 1, 0,  1, 0, 0,  0, 0, 1, 1)); // 22 LOAD R0
    tbl.push_back(mkv(1, 0, 0, 1, 0, 6, 1, 0, 0,  1, 0, 0,  0, 0, 1, 1)); // 23 R0 reader: no stall
    tbl.push_back(mkv(1, 1, 2, 1, 1, 9, 0, 0, 0,  1, 0, 0,  0, 0, 1, 1)); // 24 non-writing instr
    tbl.push_back(mkv(1, 9, 0, 1, 0, 3, 1, 0, 0,  1, 0, 0,  0, 0, 1, 1)); // 25 wr_en=0: no fwd

    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_we", int'(pc_we), 1);
    chk("rst_ifid_we", int'(ifid_we), 1);
    chk("rst_flush", int'(flush), 0);
    chk("rst_bubble", int'(bub), 0);
    chk("rst_fwd1", int'(f1), 0);
    chk("rst_fwd2", int'(f2), 0);
    chk("rst_stall_cnt", int'(sc), 0);
    chk("rst_flush_cnt", int'(fc), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, int'(tbl[i].s1), int'(tbl[i].s2), tbl[i].u1, tbl[i].u2,
            int'(tbl[i].d), tbl[i].wr, tbl[i].ld, tbl[i].br);
      #2;
      chk($sformatf("v%0d_pc_we", i), int'(pc_we), int'(tbl[i].pcwe));
      chk($sformatf("v%0d_ifid_we", i), int'(ifid_we), int'(tbl[i].pcwe));
      chk($sformatf("v%0d_flush", i), int'(flush), int'(tbl[i].fl));
      chk($sformatf("v%0d_bubble", i), int'(bub), int'(tbl[i].bub));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fwd1", i), int'(f1), int'(tbl[i].f1));
      chk($sformatf("v%0d_fwd2", i), int'(f2), int'(tbl[i].f2));
      chk($sformatf("v%0d_stall_cnt", i), int'(sc), tbl[i].sc);
      chk($sformatf("v%0d_flush_cnt", i), int'(fc), tbl[i].fc);
    end

    // Self-dependent load issued back to back: stalls every other cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
      #2;
      chk($sformatf("sat_pc_we_%0d", i), int'(pc_we), (i % 2 == 0) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    // Ten taken-branch cycles with nothing in Decode.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      #2;
      chk($sformatf("br_flush_%0d", i), int'(flush), 1);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("big_stall_cnt", int'(sc), 11);
    chk("big_flush_cnt", int'(fc), 11);
    chk("small_stall_cnt_sat", int'(s_sc), sat_small(11));
    chk("small_flush_cnt_sat", int'(s_fc), sat_small(11));
    @(posedge clk);
    #1;
    chk("small_stall_cnt_hold", int'(s_sc), 7);

    // Reset in the middle of a pending load-use hazard.
    drive(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 2, 0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", int'(pc_we), 0);
    reset = 1'b1;
    #1;
    chk("async_rst_pc_we", int'(pc_we), 1);
    chk("async_rst_bubble", int'(bub), 0);
    chk("async_rst_stall_cnt", int'(sc), 0);
    chk("async_rst_flush_cnt", int'(fc), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_fwd1", int'(f1), 0);
    chk("post_rst_stall_cnt", int'(sc), 0);
    drive(1'b1, 4, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_issued_fwd1", int'(f1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
